score_keeper: RTL and testbench
===============================

# score_keeper

Two-player score register and digit decoder for Pong. Counts points from the ball/collision logic and sequences serve-wait, play and game-over phases. Produces per-digit seven-segment enables that drive the `data` input of the segment rectangle instances in the score overlay. Display outputs update only at frame boundaries, so a digit never changes mid-scan.

## Interface
Parameters:
- WIN_SCORE, 11, score that ends the game; legal range 1..99.
- SERVE_FRAMES, 120, frames of serve hold after reset, a point or new_game; legal range 1..1023.

Ports:
- clk  in  1  pixel/system clock.
- rst_n  in  1  asynchronous, active-low reset.
- point_l  in  1  one-cycle pulse: left player scored.
- point_r  in  1  one-cycle pulse: right player scored.
- frame_start  in  1  one-cycle pulse, once per frame at the start of vertical blank.
- new_game  in  1  one-cycle pulse: clear scores and restart.
- score_l, score_r  out  7 each  binary scores, 0..99.
- seg_l_tens, seg_l_ones, seg_r_tens, seg_r_ones  out  7 each  segment enables; bit0=a … bit6=g, active high.
- serve_en  out  1  high only in PLAY; the ball logic may launch/move.
- game_over  out  1  high in OVER.
- winner  out  1  0 = left, 1 = right; valid while game_over = 1.

## Operation
- Scores are held as two BCD digits per player (tens, ones); the ones digit wraps 9→0 with a tens carry. score_l and score_r are the binary equivalent, computed as tens*10+ones.
- FSM states:
  - SERVE: serve_en = 0. A 10-bit frame counter counts frame_start pulses. On the SERVE_FRAMES-th pulse, go to PLAY and clear the counter.
  - PLAY: serve_en = 1. A single point pulse increments that player's score.
    - If the new score equals WIN_SCORE: go to OVER and latch winner.
    - Otherwise: go to SERVE with the counter at 0.
  - OVER: hold scores and winner; wait for new_game.
- Points in SERVE or OVER are ignored.
- point_l and point_r in the same cycle (PLAY): both ignored, no state change.
- new_game in any state:
  - clears all BCD digits and the frame counter, and clears winner to 0;
  - enters SERVE;
  - takes priority over point pulses in the same cycle.
- Display snapshot:
  - On frame_start, the four seg outputs load the decode of the current registered BCD digits.
  - If point and frame_start coincide, the snapshot shows the pre-point score.
- Leading-zero blank: a tens digit of 0 decodes to 7'h00.
- Decode values (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.

## Timing
- Reset values:
  - State SERVE, counter 0, scores 0, winner 0.
  - serve_en 0, game_over 0.
  - All seg outputs 7'h00. The blank ones digit is intentional: the display reads blank until the first frame_start.
- Point pulse at cycle N: score_* and state are updated at N+1. serve_en falls and game_over rises at N+1.
- seg outputs change exactly one cycle after a frame_start pulse and are otherwise stable.
- SERVE→PLAY: serve_en rises one cycle after the SERVE_FRAMES-th frame_start.
- A frame_start coinciding with the transition into SERVE does not count.
- new_game at cycle N: scores read 0 at N+1; seg outputs show 0 after the next frame_start.
- Reset asserted mid-game returns every output to its reset value immediately, asynchronously.

## Structure
- Package pong_score_pkg holds:
  - the state enum (SERVE, PLAY, OVER);
  - the segment width constant (7);
  - the ten digit-to-segment constants;
  - the blank constant 7'h00.
- Sub-module seg7_decode: combinational, 4-bit BCD plus blank_zero in, 7-bit segments out. Instantiated four times, with blank_zero tied high for the tens digits.
- All registers in score_keeper use async active-low reset. No other clock domains.

## Test plan
- Reset, then 120 frame_start pulses → serve_en = 1 one cycle after the 120th. After the next frame_start, seg_l_ones = 7'h3F and seg_l_tens = 7'h00.
- Reach PLAY, point_l pulse → score_l = 1 and serve_en = 0 next cycle. After the next frame_start, seg_l_ones = 7'h06. serve_en returns after another 120 frames.
- Right player scores 10 points → score_r = 10, seg_r_tens = 7'h06, seg_r_ones = 7'h3F.
- Right player scores the 11th point → game_over = 1 and winner = 1 next cycle. Further point_l/point_r pulses leave the scores unchanged.
- point_l and point_r in the same cycle during PLAY → no score change, serve_en stays 1. point_l coincident with frame_start → seg shows the old digit until the following frame_start.
- new_game together with point_l while in OVER → scores 0, game_over 0, state SERVE. Assert rst_n low mid-PLAY → every output returns to its reset value without a clock edge.

Source files
------------

// File: rtl/pong_score_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pong_score_pkg                                                     |
// | Shared types and seven-segment constants for the Pong score logic. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pong_score_pkg;

  localparam int c_seg_w = 7;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_t;

  // Segment patterns, bit0 = a ... bit6 = g
  localparam logic [c_seg_w-1:0] c_seg_0     = 7'h3F;
  localparam logic [c_seg_w-1:0] c_seg_1     = 7'h06;
  localparam logic [c_seg_w-1:0] c_seg_2     = 7'h5B;
  localparam logic [c_seg_w-1:0] c_seg_3     = 7'h4F;
  localparam logic [c_seg_w-1:0] c_seg_4     = 7'h66;
  localparam logic [c_seg_w-1:0] c_seg_5     = 7'h6D;
  localparam logic [c_seg_w-1:0] c_seg_6     = 7'h7D;
  localparam logic [c_seg_w-1:0] c_seg_7     = 7'h07;
  localparam logic [c_seg_w-1:0] c_seg_8     = 7'h7F;
  localparam logic [c_seg_w-1:0] c_seg_9     = 7'h6F;
  localparam logic [c_seg_w-1:0] c_seg_blank = 7'h00;

  function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_decode                                                        |
// | Combinational BCD digit to seven-segment decoder, optional blank.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seg7_decode
  import pong_score_pkg::*;
(
  input  logic [3:0]         i_bcd,
  input  logic               i_blank_zero,
  output logic [c_seg_w-1:0] o_seg
);

  always_comb begin
    o_seg = c_seg_blank;
    case (i_bcd)
      4'd0:    o_seg = i_blank_zero ? c_seg_blank : c_seg_0;
      4'd1:    o_seg = c_seg_1;
      4'd2:    o_seg = c_seg_2;
      4'd3:    o_seg = c_seg_3;
      4'd4:    o_seg = c_seg_4;
      4'd5:    o_seg = c_seg_5;
      4'd6:    o_seg = c_seg_6;
      4'd7:    o_seg = c_seg_7;
      4'd8:    o_seg = c_seg_8;
      4'd9:    o_seg = c_seg_9;
      default: o_seg = c_seg_blank;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | score_keeper                                                       |
// | Two-player BCD score, serve/play/over sequencing, frame-synced     |
// | seven-segment digit outputs.                                       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module score_keeper
  import pong_score_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned SERVE_FRAMES = 120
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               point_l,
  input  logic               point_r,
  input  logic               frame_start,
  input  logic               new_game,
  output logic [6:0]         score_l,
  output logic [6:0]         score_r,
  output logic [c_seg_w-1:0] seg_l_tens,
  output logic [c_seg_w-1:0] seg_l_ones,
  output logic [c_seg_w-1:0] seg_r_tens,
  output logic [c_seg_w-1:0] seg_r_ones,
  output logic               serve_en,
  output logic               game_over,
  output logic               winner
);

  localparam logic [9:0] c_last_frame = 10'(SERVE_FRAMES - 1);
  localparam logic [6:0] c_win        = 7'(WIN_SCORE);

  state_t     r_state, w_state_nxt;
  logic [9:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_l_tens, r_l_ones, r_r_tens, r_r_ones;
  logic [3:0] w_l_tens_nxt, w_l_ones_nxt, w_r_tens_nxt, w_r_ones_nxt;
  logic [3:0] w_l_tens_inc, w_l_ones_inc, w_r_tens_inc, w_r_ones_inc;
  logic       r_winner, w_winner_nxt;
  logic [c_seg_w-1:0] r_seg_l_tens, r_seg_l_ones, r_seg_r_tens, r_seg_r_ones;
  logic [c_seg_w-1:0] w_dec_l_tens, w_dec_l_ones, w_dec_r_tens, w_dec_r_ones;

  seg7_decode u_dec_l_tens (.i_bcd(r_l_tens), .i_blank_zero(1'b1), .o_seg(w_dec_l_tens));
  seg7_decode u_dec_l_ones (.i_bcd(r_l_ones), .i_blank_zero(1'b0), .o_seg(w_dec_l_ones));
  seg7_decode u_dec_r_tens (.i_bcd(r_r_tens), .i_blank_zero(1'b1), .o_seg(w_dec_r_tens));
  seg7_decode u_dec_r_ones (.i_bcd(r_r_ones), .i_blank_zero(1'b0), .o_seg(w_dec_r_ones));

  // BCD increment with ones-to-tens carry
  always_comb begin
    w_l_ones_inc = (r_l_ones == 4'd9) ? 4'd0 : r_l_ones + 4'd1;
    w_r_ones_inc = (r_r_ones == 4'd9) ? 4'd0 : r_r_ones + 4'd1;
    w_l_tens_inc = r_l_tens;
    w_r_tens_inc = r_r_tens;
    if (r_l_ones == 4'd9) w_l_tens_inc = (r_l_tens == 4'd9) ? 4'd0 : r_l_tens + 4'd1;
    if (r_r_ones == 4'd9) w_r_tens_inc = (r_r_tens == 4'd9) ? 4'd0 : r_r_tens + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SERVE;
      r_cnt        <= '0;
      r_l_tens     <= '0;
      r_l_ones     <= '0;
      r_r_tens     <= '0;
      r_r_ones     <= '0;
      r_winner     <= 1'b0;
      r_seg_l_tens <= c_seg_blank;
      r_seg_l_ones <= c_seg_blank;
      r_seg_r_tens <= c_seg_blank;
      r_seg_r_ones <= c_seg_blank;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_l_tens <= w_l_tens_nxt;
      r_l_ones <= w_l_ones_nxt;
      r_r_tens <= w_r_tens_nxt;
      r_r_ones <= w_r_ones_nxt;
      r_winner <= w_winner_nxt;
      // Snapshot uses the pre-update digits so a coincident point shows next frame
      if (frame_start) begin
        r_seg_l_tens <= w_dec_l_tens;
        r_seg_l_ones <= w_dec_l_ones;
        r_seg_r_tens <= w_dec_r_tens;
        r_seg_r_ones <= w_dec_r_ones;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_l_tens_nxt = r_l_tens;
    w_l_ones_nxt = r_l_ones;
    w_r_tens_nxt = r_r_tens;
    w_r_ones_nxt = r_r_ones;
    w_winner_nxt = r_winner;
    if (new_game) begin
      w_state_nxt  = SERVE;
      w_cnt_nxt    = '0;
      w_l_tens_nxt = '0;
      w_l_ones_nxt = '0;
      w_r_tens_nxt = '0;
      w_r_ones_nxt = '0;
      w_winner_nxt = 1'b0;
    end else begin
      case (r_state)
        SERVE: begin
          if (frame_start) begin
            if (r_cnt == c_last_frame) begin
              w_state_nxt = PLAY;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + 10'd1;
            end
          end
        end
        PLAY: begin
          if (point_l ^ point_r) begin
            w_state_nxt = SERVE;
            w_cnt_nxt   = '0;
            if (point_l) begin
              w_l_tens_nxt = w_l_tens_inc;
              w_l_ones_nxt = w_l_ones_inc;
              if (bcd_to_bin(w_l_tens_inc, w_l_ones_inc) == c_win) begin
                w_state_nxt  = OVER;
                w_winner_nxt = 1'b0;
              end
            end else begin
              w_r_tens_nxt = w_r_tens_inc;
              w_r_ones_nxt = w_r_ones_inc;
              if (bcd_to_bin(w_r_tens_inc, w_r_ones_inc) == c_win) begin
                w_state_nxt  = OVER;
                w_winner_nxt = 1'b1;
              end
            end
          end
        end
        OVER:    w_state_nxt = OVER;
        default: w_state_nxt = SERVE;
      endcase
    end
  end

  always_comb begin
    serve_en   = (r_state == PLAY);
    game_over  = (r_state == OVER);
    winner     = r_winner;
    score_l    = bcd_to_bin(r_l_tens, r_l_ones);
    score_r    = bcd_to_bin(r_r_tens, r_r_ones);
    seg_l_tens = r_seg_l_tens;
    seg_l_ones = r_seg_l_ones;
    seg_r_tens = r_seg_r_tens;
    seg_r_ones = r_seg_r_ones;
  end

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_score_keeper                                                    |
// | Randomized bench against a score/phase reference model.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_score_keeper;

  localparam int WIN    = 11;
  localparam int FRAMES = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic point_l = 1'b0, point_r = 1'b0, frame_start = 1'b0, new_game = 1'b0;
  logic [6:0] score_l, score_r, seg_l_tens, seg_l_ones, seg_r_tens, seg_r_ones;
  logic serve_en, game_over, winner;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: decimal scores, phase 0=serve 1=play 2=over
  int m_sl, m_sr, m_phase, m_frames, m_win;
  logic [6:0] m_seg [4];
  logic [6:0] seg_tab [10];

  always #5 clk = ~clk;

  score_keeper #(.WIN_SCORE(WIN), .SERVE_FRAMES(FRAMES)) dut (
    .clk(clk), .rst_n(rst_n), .point_l(point_l), .point_r(point_r),
    .frame_start(frame_start), .new_game(new_game),
    .score_l(score_l), .score_r(score_r),
    .seg_l_tens(seg_l_tens), .seg_l_ones(seg_l_ones),
    .seg_r_tens(seg_r_tens), .seg_r_ones(seg_r_ones),
    .serve_en(serve_en), .game_over(game_over), .winner(winner)
  );

  function automatic logic [6:0] tens_seg(input int s);
    return (s / 10 == 0) ? 7'h00 : seg_tab[s / 10];
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("score_l", score_l, 7'(m_sl));
    chk("score_r", score_r, 7'(m_sr));
    chk("seg_l_tens", seg_l_tens, m_seg[0]);
    chk("seg_l_ones", seg_l_ones, m_seg[1]);
    chk("seg_r_tens", seg_r_tens, m_seg[2]);
    chk("seg_r_ones", seg_r_ones, m_seg[3]);
    chk("serve_en", {6'b0, serve_en}, {6'b0, m_phase == 1});
    chk("game_over", {6'b0, game_over}, {6'b0, m_phase == 2});
    chk("winner", {6'b0, winner}, 7'(m_win));
  endtask

  task automatic model_reset();
    m_sl = 0; m_sr = 0; m_phase = 0; m_frames = 0; m_win = 0;
    for (int k = 0; k < 4; k++) m_seg[k] = 7'h00;
  endtask

  task automatic step(input bit pl, input bit pr, input bit fs, input bit ng);
    point_l = pl; point_r = pr; frame_start = fs; new_game = ng;
    @(posedge clk);
    if (fs) begin
      m_seg[0] = tens_seg(m_sl); m_seg[1] = seg_tab[m_sl % 10];
      m_seg[2] = tens_seg(m_sr); m_seg[3] = seg_tab[m_sr % 10];
    end
    if (ng) begin
      m_sl = 0; m_sr = 0; m_phase = 0; m_frames = 0; m_win = 0;
    end else if (m_phase == 0) begin
      if (fs) begin
        m_frames++;
        if (m_frames == FRAMES) begin m_phase = 1; m_frames = 0; end
      end
    end else if (m_phase == 1 && (pl != pr)) begin
      if (pl) m_sl++; else m_sr++;
      if ((pl ? m_sl : m_sr) == WIN) begin m_phase = 2; m_win = pr ? 1 : 0; end
      else begin m_phase = 0; m_frames = 0; end
    end
    #1;
    point_l = 0; point_r = 0; frame_start = 0; new_game = 0;
    check_all();
  endtask

  task automatic reach_play();
    for (int i = 0; i < 2000 && m_phase != 1; i++) step(0, 0, $urandom_range(0, 1) == 1, 0);
    chk("reach_play", {6'b0, serve_en}, 7'd1);
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Serve hold then the first snapshot
    for (int i = 0; i < FRAMES; i++) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);

    // Random game to completion
    for (int i = 0; i < 30000 && m_phase != 2; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 0);
    chk("reach_over", {6'b0, game_over}, 7'd1);
    for (int i = 0; i < 8; i++) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, i[0], 0);

    // new_game beats a coincident point
    step(1, 0, 0, 1);
    step(0, 0, 1, 0);

    reach_play();
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);

    reach_play();
    step(0, 1, 0, 0);
    reach_play();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
